// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, baud divisor table, receiver FSM
// state encoding and the even-parity helper.
package uart_pkg;

  localparam int unsigned DATA_BITS  = 32'd8;
  localparam int unsigned OVERSAMPLE = 32'd16;
  localparam int unsigned FRAME_BITS = 32'd11;
  localparam int unsigned DIV_W      = 32'd16;

  // Baud rates indexed by the 3-bit rate code.
  localparam int unsigned BAUD_RATE [8] = '{
    32'd300, 32'd1200, 32'd4800, 32'd9600,
    32'd19200, 32'd38400, 32'd57600, 32'd115200
  };

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // Clocks per sample tick for a rate code, rounded to nearest.
  function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] code,
                                                input int unsigned clk_hz);
    int unsigned rate_x16;
    rate_x16 = BAUD_RATE[code] * OVERSAMPLE;
    return DIV_W'((clk_hz + rate_x16 / 32'd2) / rate_x16);
  endfunction

  // Even parity: 1 when the byte holds an odd number of ones.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/baud_controller.sv
// Sample-tick generator: one-clock sample_en pulse every DIV clocks, where
// DIV is chosen by baud_select. Changing baud_select restarts the count.
module baud_controller
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 32'd50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  output logic       sample_en
);

  localparam logic [DIV_W-1:0] DIV_TAB [8] = '{
    baud_div(3'd0, CLK_FREQ_HZ), baud_div(3'd1, CLK_FREQ_HZ),
    baud_div(3'd2, CLK_FREQ_HZ), baud_div(3'd3, CLK_FREQ_HZ),
    baud_div(3'd4, CLK_FREQ_HZ), baud_div(3'd5, CLK_FREQ_HZ),
    baud_div(3'd6, CLK_FREQ_HZ), baud_div(3'd7, CLK_FREQ_HZ)
  };

  logic [DIV_W-1:0] w_div;
  logic [DIV_W-1:0] r_cnt;
  logic [2:0]       r_sel;
  logic             r_sample_en;

  assign w_div     = DIV_TAB[baud_select];
  assign sample_en = r_sample_en;

  // Divide the clock; a rate change reloads the counter so the new rate starts cleanly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_sel       <= 3'd0;
      r_sample_en <= 1'b0;
    end else if (baud_select != r_sel) begin
      r_sel       <= baud_select;
      r_cnt       <= '0;
      r_sample_en <= 1'b0;
    end else if (r_cnt >= (w_div - DIV_W'(1))) begin
      r_cnt       <= '0;
      r_sample_en <= 1'b1;
    end else begin
      r_cnt       <= r_cnt + DIV_W'(1);
      r_sample_en <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 2-FF synchronizer, 16x oversampled frame FSM
// (start, 8 data LSB-first, even parity, stop) and held result flags.
// Optional build macro RX_MAJORITY_VOTE_EN: each bit is the 2-of-3 majority
// of ticks 6/7/8, decided at tick 8; otherwise a single sample at tick 7.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 32'd50000000,
  parameter int unsigned OVERSAMPLE  = 32'd16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Rx_EN,
  input  logic       RxD,
  output logic [7:0] Rx_DATA,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR,
  output logic       Rx_VALID
);

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 32'd1);
`ifdef RX_MAJORITY_VOTE_EN
  localparam logic [3:0] DECIDE_TICK = 4'd8;
`else
  localparam logic [3:0] DECIDE_TICK = 4'd7;
`endif

  logic       w_sample_en;
  logic       r_sync1, r_sync2;
  rx_state_e  r_state, w_next_state;
  logic [3:0] r_tick_cnt;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_par_err;
  logic       r_armed;
  logic [7:0] r_data;
  logic       r_perror, r_ferror, r_valid;
  logic       w_bit, w_decide, w_bit_end, w_start;

  baud_controller #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_baud (
    .clk        (clk),
    .reset      (reset),
    .baud_select(baud_select),
    .sample_en  (w_sample_en)
  );

  // Bring the asynchronous line into the clock domain; idle level is 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= RxD;
      r_sync2 <= r_sync1;
    end
  end

`ifdef RX_MAJORITY_VOTE_EN
  logic r_s6, r_s7;

  // Hold the tick-6 and tick-7 samples for the vote taken at tick 8.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s6 <= 1'b1;
      r_s7 <= 1'b1;
    end else if (w_sample_en) begin
      if (r_tick_cnt == 4'd6) r_s6 <= r_sync2;
      if (r_tick_cnt == 4'd7) r_s7 <= r_sync2;
    end
  end

  assign w_bit = (r_s6 & r_s7) | (r_s6 & r_sync2) | (r_s7 & r_sync2);
`else
  assign w_bit = r_sync2;
`endif

  assign w_decide  = w_sample_en && (r_tick_cnt == DECIDE_TICK);
  assign w_bit_end = w_sample_en && (r_tick_cnt == TICK_LAST);
  assign w_start   = (r_state == ST_IDLE) && Rx_EN && r_armed && !r_sync2;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic; disabling the receiver drops any partial frame.
  always_comb begin
    w_next_state = r_state;
    if (!Rx_EN) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (w_start) w_next_state = ST_START;
                   else w_next_state = ST_IDLE;
        ST_START:  if (w_decide && w_bit) w_next_state = ST_IDLE;
                   else if (w_bit_end) w_next_state = ST_DATA;
                   else w_next_state = ST_START;
        ST_DATA:   if (w_bit_end && (r_bit_cnt == 3'd7)) w_next_state = ST_PARITY;
                   else w_next_state = ST_DATA;
        ST_PARITY: if (w_bit_end) w_next_state = ST_STOP;
                   else w_next_state = ST_PARITY;
        ST_STOP:   if (w_decide) w_next_state = ST_IDLE;
                   else w_next_state = ST_STOP;
        default:   w_next_state = ST_IDLE;
      endcase
    end
  end

  // Frame datapath: tick/bit counters, shift register, parity, re-arm and result flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick_cnt <= 4'd0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
      r_par_err  <= 1'b0;
      r_armed    <= 1'b0;
      r_data     <= 8'h00;
      r_perror   <= 1'b0;
      r_ferror   <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) begin
        r_tick_cnt <= 4'd0;
        r_bit_cnt  <= 3'd0;
      end else if (w_sample_en) begin
        r_tick_cnt <= r_tick_cnt + 4'd1;
        if ((r_state == ST_DATA) && (r_tick_cnt == TICK_LAST)) r_bit_cnt <= r_bit_cnt + 3'd1;
      end

      if ((r_state == ST_DATA) && w_decide) r_shift <= {w_bit, r_shift[7:1]};
      if ((r_state == ST_PARITY) && w_decide) r_par_err <= even_parity(r_shift) ^ w_bit;

      // A start is only accepted after the line was seen high in IDLE (no start on a break).
      if (r_state == ST_IDLE) begin
        if (w_start)      r_armed <= 1'b0;
        else if (r_sync2) r_armed <= 1'b1;
      end else begin
        r_armed <= 1'b0;
      end

      if (w_start) begin
        r_valid  <= 1'b0;
        r_perror <= 1'b0;
        r_ferror <= 1'b0;
      end else if ((r_state == ST_STOP) && w_decide && Rx_EN) begin
        r_data   <= r_shift;
        r_ferror <= ~w_bit;
        r_perror <= r_par_err;
        r_valid  <= w_bit & ~r_par_err;
      end
    end
  end

  assign Rx_DATA   = r_data;
  assign Rx_PERROR = r_perror;
  assign Rx_FERROR = r_ferror;
  assign Rx_VALID  = r_valid;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: frames are driven bit by bit, the
// expected result is queued when a frame is driven and compared against the
// results captured whenever a result flag rises.
module tb_uart_receiver;
  import uart_pkg::*;

  typedef logic [10:0] res_t; // {data, valid, perror, ferror}

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] baud_select = 3'b111;
  logic       Rx_EN = 1'b1;
  logic       RxD = 1'b1;
  logic [7:0] Rx_DATA;
  logic       Rx_PERROR, Rx_FERROR, Rx_VALID;

  int   errors = 0;
  int   checks = 0;
  int   cur_div = 27;
  res_t exp_q[$];
  res_t obs_q[$];
  res_t e_r, o_r;
  logic mon_prev = 1'b0;
  logic mon_now;

  uart_receiver dut (
    .clk(clk), .reset(reset), .baud_select(baud_select), .Rx_EN(Rx_EN), .RxD(RxD),
    .Rx_DATA(Rx_DATA), .Rx_PERROR(Rx_PERROR), .Rx_FERROR(Rx_FERROR), .Rx_VALID(Rx_VALID)
  );

  always #5 clk = ~clk;

  // Capture the outputs each time a frame result appears.
  always @(negedge clk) begin
    mon_now = Rx_VALID | Rx_PERROR | Rx_FERROR;
    if (mon_now && !mon_prev) obs_q.push_back({Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR});
    mon_prev = mon_now;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic idle_bits(input int n);
    RxD = 1'b1;
    repeat (n * 16 * cur_div) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                            input bit expect_out, input bit spike);
    logic [10:0] frame;
    int bt;
    int pre;
    bt    = 16 * cur_div;
    pre   = 7 * cur_div + cur_div / 2;
    frame = {stop, par, data, 1'b0};
    if (expect_out)
      exp_q.push_back({data, (par == ^data) && stop, par != ^data, !stop});
    for (int i = 0; i < 11; i++) begin
      RxD = frame[i];
      if (spike && i >= 1 && i <= 8) begin
        repeat (pre) @(negedge clk);
        RxD = ~frame[i];
        @(negedge clk);
        RxD = frame[i];
        repeat (bt - pre - 1) @(negedge clk);
      end else begin
        repeat (bt) @(negedge clk);
      end
    end
  endtask

  task automatic wait_obs(input int n);
    for (int k = 0; k < 20000 && obs_q.size() < n; k++) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR} !== 11'h000) begin
      errors++; $display("FAIL reset_outputs: got %h expected 000", {Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR});
    end
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR} !== 11'h000 || dut.r_state !== ST_IDLE) begin
      errors++; $display("FAIL after_reset: got %h state %0d expected 000 state 0",
                         {Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR}, dut.r_state);
    end
  endtask

  task automatic test_baud_div();
    logic [2:0] codes [4];
    int         divs [4];
    int         cnt;
    codes = '{3'b111, 3'b110, 3'b100, 3'b011};
    divs  = '{27, 54, 163, 326};
    for (int i = 0; i < 4; i++) begin
      baud_select = codes[i];
      repeat (3) @(negedge clk);
      for (int k = 0; k < 20000 && !dut.w_sample_en; k++) @(negedge clk);
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!dut.w_sample_en && cnt < 20000);
      checks++;
      if (cnt !== divs[i]) begin
        errors++; $display("FAIL baud_div code %b: period %0d expected %0d", codes[i], cnt, divs[i]);
      end
    end
    baud_select = 3'b111;
    cur_div = 27;
    idle_bits(1);
  endtask

  task automatic test_single_frame();
    send_frame(8'hA8, 1'b1, 1'b1, 1'b1, 1'b0);
    idle_bits(2);
    wait_obs(1);
    checks++;
    if (obs_q.size() !== 1) begin errors++; $display("FAIL single_count: got %0d expected 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e_r = exp_q.pop_front(); o_r = obs_q.pop_front(); checks++;
      if (o_r !== e_r) begin errors++; $display("FAIL single_frame: got %h expected %h", o_r, e_r); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    send_frame(8'hA8, 1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(8'h88, 1'b0, 1'b1, 1'b1, 1'b0);
    idle_bits(2);
    wait_obs(2);
    checks++;
    if (obs_q.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e_r = exp_q.pop_front(); o_r = obs_q.pop_front(); checks++;
      if (o_r !== e_r) begin errors++; $display("FAIL back_to_back: got %h expected %h", o_r, e_r); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_errors();
    send_frame(8'h88, 1'b1, 1'b1, 1'b1, 1'b0);
    idle_bits(2);
    send_frame(8'h88, 1'b0, 1'b0, 1'b1, 1'b0);
    RxD = 1'b0;
    repeat (3 * 16 * cur_div) @(negedge clk);
    checks++;
    if ({Rx_VALID, Rx_PERROR, Rx_FERROR} !== 3'b001) begin
      errors++; $display("FAIL break_no_restart: flags %b expected 001", {Rx_VALID, Rx_PERROR, Rx_FERROR});
    end
    idle_bits(2);
    wait_obs(2);
    checks++;
    if (obs_q.size() !== 2) begin errors++; $display("FAIL err_count: got %0d expected 2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e_r = exp_q.pop_front(); o_r = obs_q.pop_front(); checks++;
      if (o_r !== e_r) begin errors++; $display("FAIL error_frame: got %h expected %h", o_r, e_r); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_glitch();
    baud_select = 3'b011;
    cur_div = 326;
    idle_bits(1);
    RxD = 1'b0;
    repeat (4 * cur_div) @(negedge clk);
    RxD = 1'b1;
    repeat (12 * cur_div) @(negedge clk);
    checks++;
    if ({Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR} !== {8'h88, 3'b000} || dut.r_state !== ST_IDLE
        || obs_q.size() !== 0) begin
      errors++; $display("FAIL glitch: got %h state %0d results %0d expected %h state 0 results 0",
                         {Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR}, dut.r_state, obs_q.size(), {8'h88, 3'b000});
    end
    baud_select = 3'b111;
    cur_div = 27;
    idle_bits(1);
    send_frame(8'hA8, 1'b1, 1'b1, 1'b1, 1'b0);
    idle_bits(2);
    wait_obs(1);
    checks++;
    if (obs_q.size() !== 1) begin errors++; $display("FAIL post_glitch_count: got %0d expected 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e_r = exp_q.pop_front(); o_r = obs_q.pop_front(); checks++;
      if (o_r !== e_r) begin errors++; $display("FAIL post_glitch_frame: got %h expected %h", o_r, e_r); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    fork
      send_frame(8'hF8, 1'b1, 1'b1, 1'b0, 1'b0);
      begin
        repeat (16 * cur_div * 4 + 8 * cur_div) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR} !== 11'h000 || dut.r_state !== ST_IDLE) begin
          errors++; $display("FAIL mid_reset: got %h state %0d expected 000 state 0",
                             {Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR}, dut.r_state);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
      end
    join
    idle_bits(2);
    checks++;
    if ({Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR} !== 11'h000 || obs_q.size() !== 0) begin
      errors++; $display("FAIL frame_remainder_ignored: got %h results %0d expected 000 results 0",
                         {Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR}, obs_q.size());
    end
    send_frame(8'h55, 1'b0, 1'b1, 1'b1, 1'b0);
    idle_bits(2);
    wait_obs(1);
    checks++;
    if (obs_q.size() !== 1) begin errors++; $display("FAIL post_reset_count: got %0d expected 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e_r = exp_q.pop_front(); o_r = obs_q.pop_front(); checks++;
      if (o_r !== e_r) begin errors++; $display("FAIL post_reset_frame: got %h expected %h", o_r, e_r); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_rx_enable();
    fork
      send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 1'b0);
      begin
        repeat (16 * cur_div * 3 + 8 * cur_div) @(negedge clk);
        Rx_EN = 1'b0;
      end
    join
    idle_bits(2);
    checks++;
    if ({Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR} !== {8'h55, 3'b000} || dut.r_state !== ST_IDLE
        || obs_q.size() !== 0) begin
      errors++; $display("FAIL rx_en_discard: got %h state %0d results %0d expected %h state 0 results 0",
                         {Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR}, dut.r_state, obs_q.size(), {8'h55, 3'b000});
    end
    Rx_EN = 1'b1;
    idle_bits(1);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
    idle_bits(2);
`ifdef RX_MAJORITY_VOTE_EN
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b1);
    idle_bits(2);
`endif
    wait_obs(exp_q.size());
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL rx_en_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e_r = exp_q.pop_front(); o_r = obs_q.pop_front(); checks++;
      if (o_r !== e_r) begin errors++; $display("FAIL rx_en_frame: got %h expected %h", o_r, e_r); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_baud_div();
    test_single_frame();
    test_back_to_back();
    test_errors();
    test_glitch();
    test_reset_mid_frame();
    test_rx_enable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
